// File: rtl/hazard_forward_unit.sv
// Pipeline hazard/forwarding controller: stall/flush/freeze decisions plus registered EX operand selects.
// Optional stall-cycle counter output STALL_COUNT is built when HAZARD_STALL_COUNT_EN is defined.
module hazard_forward_unit (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_RS1_USE,
  input  logic       ID_RS2_USE,
  input  logic [4:0] ID_RD,
  input  logic       ID_REG_WRITE,
  input  logic       ID_MEM_READ,
  input  logic       MEM_BUSY,
  input  logic       BRANCH_TAKEN,
  output logic [1:0] FWD_SEL1,
  output logic [1:0] FWD_SEL2,
  output logic       PC_WRITE,
  output logic       IFID_WRITE,
  output logic       BUBBLE,
  output logic       FLUSH,
  output logic       PC_SEL
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0] STALL_COUNT
`endif
);

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_BUBBLE,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_e;

  stage_t ex_q, mem_q, wb_q;
  logic [1:0] fwd1_q, fwd2_q;
  mode_e mode;
  logic load_use;

  // Newer stage (EX) wins over MEM; x0 is never a forwarding source.
  function automatic logic [1:0] pick_fwd(input logic [4:0] rs, input stage_t ex, input stage_t mem);
    if (ex.reg_write && (ex.rd != '0) && (ex.rd == rs))
      return 2'b01;
    else if (mem.reg_write && (mem.rd != '0) && (mem.rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                    ((ID_RS1_USE && (ID_RS1 == ex_q.rd)) ||
                     (ID_RS2_USE && (ID_RS2 == ex_q.rd)));

  always_comb begin
    if (MEM_BUSY)
      mode = MODE_FREEZE;
    else if (BRANCH_TAKEN)
      mode = MODE_FLUSH;
    else if (load_use)
      mode = MODE_BUBBLE;
    else
      mode = MODE_RUN;
  end

  always_comb begin
    PC_WRITE   = 1'b1;
    IFID_WRITE = 1'b1;
    BUBBLE     = 1'b0;
    FLUSH      = 1'b0;
    PC_SEL     = 1'b0;
    if (!RESET) begin
      case (mode)
        MODE_FREEZE: begin
          PC_WRITE   = 1'b0;
          IFID_WRITE = 1'b0;
        end
        MODE_FLUSH: begin
          FLUSH  = 1'b1;
          PC_SEL = 1'b1;
        end
        MODE_BUBBLE: begin
          PC_WRITE   = 1'b0;
          IFID_WRITE = 1'b0;
          BUBBLE     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      fwd1_q <= '0;
      fwd2_q <= '0;
    end else if (mode == MODE_FREEZE) begin
      ex_q   <= ex_q;
      mem_q  <= mem_q;
      wb_q   <= wb_q;
      fwd1_q <= fwd1_q;
      fwd2_q <= fwd2_q;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (mode == MODE_RUN) begin
        ex_q   <= '{rd: ID_RD, reg_write: ID_REG_WRITE, mem_read: ID_MEM_READ};
        fwd1_q <= pick_fwd(ID_RS1, ex_q, mem_q);
        fwd2_q <= pick_fwd(ID_RS2, ex_q, mem_q);
      end else begin
        ex_q   <= '0;
        fwd1_q <= '0;
        fwd2_q <= '0;
      end
    end
  end

  assign FWD_SEL1 = fwd1_q;
  assign FWD_SEL2 = fwd2_q;

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RESET)
      STALL_COUNT <= '0;
    else if (!PC_WRITE && (STALL_COUNT != '1))
      STALL_COUNT <= STALL_COUNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed table-driven bench for hazard_forward_unit, plus hand-written freeze/reset sequences.
module tb_hazard_forward_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_RS1, ID_RS2, ID_RD;
  logic       ID_RS1_USE, ID_RS2_USE, ID_REG_WRITE, ID_MEM_READ;
  logic       MEM_BUSY, BRANCH_TAKEN;
  logic [1:0] FWD_SEL1, FWD_SEL2;
  logic       PC_WRITE, IFID_WRITE, BUBBLE, FLUSH, PC_SEL;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] STALL_COUNT;
`endif

  hazard_forward_unit dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_RS1_USE(ID_RS1_USE), .ID_RS2_USE(ID_RS2_USE),
    .ID_RD(ID_RD), .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
    .MEM_BUSY(MEM_BUSY), .BRANCH_TAKEN(BRANCH_TAKEN),
    .FWD_SEL1(FWD_SEL1), .FWD_SEL2(FWD_SEL2),
    .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE), .BUBBLE(BUBBLE),
    .FLUSH(FLUSH), .PC_SEL(PC_SEL)
`ifdef HAZARD_STALL_COUNT_EN
    , .STALL_COUNT(STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Control vector order: {PC_WRITE, IFID_WRITE, BUBBLE, FLUSH, PC_SEL}
  localparam logic [4:0] RUN = 5'b11000;
  localparam logic [4:0] BUB = 5'b00100;
  localparam logic [4:0] FLS = 5'b11011;
  localparam logic [4:0] FRZ = 5'b00000;

  typedef struct {
    logic       rst, busy, br;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw, mr;
    logic [4:0] ctl;
    logic [1:0] f1, f2;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  logic [15:0] model_cnt = '0;

  function automatic vec_t mk(input logic rst, busy, br, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic rw, mr, input logic [4:0] ctl, input logic [1:0] f1, f2);
    vec_t v;
    v.rst = rst; v.busy = busy; v.br = br;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr;
    v.ctl = ctl; v.f1 = f1; v.f2 = f2;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RESET = v.rst; MEM_BUSY = v.busy; BRANCH_TAKEN = v.br;
    ID_RS1 = v.rs1; ID_RS1_USE = v.u1; ID_RS2 = v.rs2; ID_RS2_USE = v.u2;
    ID_RD = v.rd; ID_REG_WRITE = v.rw; ID_MEM_READ = v.mr;
  endtask

  initial begin
    //                rst bsy br  rs1 u1 rs2 u2 rd  rw mr  ctl  f1     f2
    vecs.push_back(mk(1, 1, 1,  1, 1,  2, 1,  5, 1, 0, RUN, 2'b00, 2'b00)); // reset overrides
    vecs.push_back(mk(0, 0, 0,  1, 1,  2, 1,  5, 1, 0, RUN, 2'b00, 2'b00)); // ADD x5
    vecs.push_back(mk(0, 0, 0,  5, 1,  6, 1,  8, 1, 0, RUN, 2'b01, 2'b00)); // SUB rs1=x5
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, RUN, 2'b00, 2'b00)); // NOP
    vecs.push_back(mk(0, 0, 0,  1, 1,  2, 1,  5, 1, 0, RUN, 2'b00, 2'b00)); // ADD x5
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, RUN, 2'b00, 2'b00)); // NOP
    vecs.push_back(mk(0, 0, 0,  3, 1,  5, 1,  9, 1, 0, RUN, 2'b00, 2'b10)); // user rs2=x5 via MEM
    vecs.push_back(mk(0, 0, 0,  1, 1,  2, 1,  5, 1, 0, RUN, 2'b00, 2'b00)); // ADD x5
    vecs.push_back(mk(0, 0, 0,  1, 1,  2, 1,  5, 1, 0, RUN, 2'b00, 2'b00)); // ADD x5
    vecs.push_back(mk(0, 0, 0,  3, 1,  5, 1, 10, 1, 0, RUN, 2'b00, 2'b01)); // newest wins
    vecs.push_back(mk(0, 0, 0,  2, 1,  0, 0,  7, 1, 1, RUN, 2'b00, 2'b00)); // LW x7
    vecs.push_back(mk(0, 0, 0,  7, 1,  4, 1, 11, 1, 0, BUB, 2'b00, 2'b00)); // load-use stall
    vecs.push_back(mk(0, 0, 0,  7, 1,  4, 1, 11, 1, 0, RUN, 2'b10, 2'b00)); // retry, MEM fwd
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 12, 1, 1, RUN, 2'b00, 2'b00)); // LW x12
    vecs.push_back(mk(0, 0, 0, 12, 0,  3, 1, 13, 1, 0, RUN, 2'b01, 2'b00)); // rs1 unused: no stall
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 14, 1, 1, RUN, 2'b00, 2'b00)); // LW x14
    vecs.push_back(mk(0, 0, 0,  1, 1, 14, 1, 15, 1, 0, BUB, 2'b00, 2'b00)); // load-use on rs2
    vecs.push_back(mk(0, 0, 0,  1, 1, 14, 1, 15, 1, 0, RUN, 2'b00, 2'b10));
    vecs.push_back(mk(0, 0, 0,  1, 1,  0, 0,  0, 1, 0, RUN, 2'b00, 2'b00)); // write x0
    vecs.push_back(mk(0, 0, 0,  0, 1,  2, 1, 16, 1, 0, RUN, 2'b00, 2'b00)); // x0 not forwarded
    vecs.push_back(mk(0, 0, 0,  3, 1,  0, 0,  0, 1, 1, RUN, 2'b00, 2'b00)); // LW x0
    vecs.push_back(mk(0, 0, 0,  0, 1,  0, 1, 17, 1, 0, RUN, 2'b00, 2'b00)); // no stall on x0
    vecs.push_back(mk(0, 0, 0,  1, 1,  2, 1, 18, 1, 0, RUN, 2'b00, 2'b00)); // ADD x18
    vecs.push_back(mk(0, 0, 1, 18, 1,  0, 0, 19, 1, 0, FLS, 2'b00, 2'b00)); // branch flush
    vecs.push_back(mk(0, 0, 0, 19, 1, 18, 1, 20, 1, 0, RUN, 2'b00, 2'b10)); // flushed x19 not fwd
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 21, 1, 1, RUN, 2'b00, 2'b00)); // LW x21
    vecs.push_back(mk(0, 0, 1, 21, 1,  0, 0, 22, 1, 0, FLS, 2'b00, 2'b00)); // branch beats load-use
    vecs.push_back(mk(0, 0, 0, 21, 1, 20, 1, 23, 1, 0, RUN, 2'b10, 2'b00));
    vecs.push_back(mk(0, 0, 0, 23, 1,  0, 0, 24, 1, 0, RUN, 2'b01, 2'b00));
    vecs.push_back(mk(0, 1, 1, 24, 1,  0, 0, 25, 1, 0, FRZ, 2'b01, 2'b00)); // busy+branch x3
    vecs.push_back(mk(0, 1, 1, 24, 1,  0, 0, 25, 1, 0, FRZ, 2'b01, 2'b00));
    vecs.push_back(mk(0, 1, 1, 24, 1,  0, 0, 25, 1, 0, FRZ, 2'b01, 2'b00));
    vecs.push_back(mk(0, 0, 1, 24, 1,  0, 0, 25, 1, 0, FLS, 2'b00, 2'b00)); // branch on cycle 4
    vecs.push_back(mk(0, 0, 0, 24, 1,  0, 0, 26, 1, 0, RUN, 2'b10, 2'b00));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 27, 1, 1, RUN, 2'b00, 2'b00)); // LW x27
    vecs.push_back(mk(0, 1, 0, 27, 1,  0, 0, 28, 1, 0, FRZ, 2'b00, 2'b00)); // busy beats load-use
    vecs.push_back(mk(0, 0, 0, 27, 1,  0, 0, 28, 1, 0, BUB, 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 0, 27, 1,  0, 0, 28, 1, 0, RUN, 2'b10, 2'b00));
    vecs.push_back(mk(0, 1, 0, 28, 1,  0, 0, 29, 1, 0, FRZ, 2'b10, 2'b00)); // frozen, fwd held
    vecs.push_back(mk(1, 1, 0, 28, 1,  0, 0, 29, 1, 0, RUN, 2'b00, 2'b00)); // reset mid-stall
    vecs.push_back(mk(0, 0, 0, 28, 1,  0, 0, 30, 1, 0, RUN, 2'b00, 2'b00)); // shadows cleared

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      #1;
      chk("ctl", i, {27'd0, PC_WRITE, IFID_WRITE, BUBBLE, FLUSH, PC_SEL}, {27'd0, vecs[i].ctl});
      @(posedge CLK);
      if (vecs[i].rst)
        model_cnt = '0;
      else if (!vecs[i].ctl[4] && model_cnt != 16'hFFFF)
        model_cnt = model_cnt + 16'd1;
      #1;
      chk("fwd", i, {28'd0, FWD_SEL1, FWD_SEL2}, {28'd0, vecs[i].f1, vecs[i].f2});
`ifdef HAZARD_STALL_COUNT_EN
      chk("stall_count", i, {16'd0, STALL_COUNT}, {16'd0, model_cnt});
`endif
    end

    // Long busy with pending branch: PC_SEL must stay low the whole time.
    @(negedge CLK);
    RESET = 1'b0; MEM_BUSY = 1'b1; BRANCH_TAKEN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("busy_pcsel", c, {30'd0, PC_SEL, PC_WRITE}, 32'd0);
      @(negedge CLK);
    end
    MEM_BUSY = 1'b0;
    #1;
    chk("busy_release", 0, {30'd0, PC_SEL, FLUSH}, 32'd3);
    @(negedge CLK);
    BRANCH_TAKEN = 1'b0;

`ifdef HAZARD_STALL_COUNT_EN
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; MEM_BUSY = 1'b1;
    for (int c = 0; c < 70000; c++) @(negedge CLK);
    chk("sat_count", 0, {16'd0, STALL_COUNT}, 32'h0000FFFF);
    chk("sat_pcw", 0, {31'd0, PC_WRITE}, 32'd0);
    RESET = 1'b1;
    #1;
    chk("rst_pcw", 0, {31'd0, PC_WRITE}, 32'd1);
    @(negedge CLK);
    chk("rst_count", 0, {16'd0, STALL_COUNT}, 32'd0);
    chk("rst_fwd", 0, {28'd0, FWD_SEL1, FWD_SEL2}, 32'd0);
    RESET = 1'b0; MEM_BUSY = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
